// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP.
// Drives datapath enables, mux selects and Imm_Sel from state and Instruction[6:0].
module multicycle_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        Instr_Valid,
  input  logic        Mem_Ready,
  input  logic        Branch_Taken,
  output logic        Instr_Req,
  output logic        IR_Load,
  output logic [1:0]  Imm_Sel,
  output logic        ALU_Src_A,
  output logic        ALU_Src_B,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [1:0]  Wb_Sel,
  output logic        Reg_Write,
  output logic        PC_Write,
  output logic        PC_Src,
  output logic        Retire,
  output logic        Illegal_Instr,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  state_e state_q, state_d;

  logic [6:0] opc;
  logic       unused_bits;
  assign opc         = Instruction[6:0];
  assign unused_bits = ^Instruction[31:7];

  logic       is_op, is_opimm, is_load, is_store, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [1:0] imm_dec;

  always_comb begin
    is_op     = 1'b0;
    is_opimm  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_lui    = 1'b0;
    is_auipc  = 1'b0;
    legal     = 1'b1;
    imm_dec   = 2'b00;
    case (opc)
      OPC_OP:     is_op     = 1'b1;
      OPC_OPIMM:  is_opimm  = 1'b1;
      OPC_LOAD:   is_load   = 1'b1;
      OPC_JALR:   is_jalr   = 1'b1;
      OPC_STORE:  begin is_store  = 1'b1; imm_dec = 2'b01; end
      OPC_BRANCH: begin is_branch = 1'b1; imm_dec = 2'b10; end
      OPC_JAL:    begin is_jal    = 1'b1; imm_dec = 2'b11; end
      OPC_LUI:    begin is_lui    = 1'b1; imm_dec = 2'b11; end
      OPC_AUIPC:  begin is_auipc  = 1'b1; imm_dec = 2'b11; end
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    Instr_Req     = 1'b0;
    IR_Load       = 1'b0;
    Imm_Sel       = 2'b00;
    ALU_Src_A     = 1'b0;
    ALU_Src_B     = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    Wb_Sel        = 2'b00;
    Reg_Write     = 1'b0;
    PC_Write      = 1'b0;
    PC_Src        = 1'b0;
    Retire        = 1'b0;
    Illegal_Instr = 1'b0;
    State         = state_q;
    unique case (state_q)
      S_FETCH: begin
        Instr_Req = 1'b1;
        if (Instr_Valid) begin
          IR_Load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        Imm_Sel = imm_dec;
        state_d = legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        Imm_Sel   = imm_dec;
        ALU_Src_A = is_auipc | is_jal | is_branch;
        ALU_Src_B = ~is_op;
        if (is_branch) begin
          PC_Write = 1'b1;
          PC_Src   = Branch_Taken;
          Retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load | is_store) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        Imm_Sel   = imm_dec;
        ALU_Src_B = 1'b1;
        Mem_Read  = is_load;
        Mem_Write = is_store;
        if (Mem_Ready) begin
          if (is_store) begin
            PC_Write = 1'b1;
            Retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        Imm_Sel   = imm_dec;
        Reg_Write = 1'b1;
        PC_Write  = 1'b1;
        Retire    = 1'b1;
        PC_Src    = is_jal | is_jalr;
        if (is_load) Wb_Sel = 2'b01;
        else if (is_jal | is_jalr) Wb_Sel = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        Illegal_Instr = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every strobe immediately, even mid-instruction.
    if (Reset) begin
      Instr_Req     = 1'b0;
      IR_Load       = 1'b0;
      Imm_Sel       = 2'b00;
      ALU_Src_A     = 1'b0;
      ALU_Src_B     = 1'b0;
      Mem_Read      = 1'b0;
      Mem_Write     = 1'b0;
      Wb_Sel        = 2'b00;
      Reg_Write     = 1'b0;
      PC_Write      = 1'b0;
      PC_Src        = 1'b0;
      Retire        = 1'b0;
      Illegal_Instr = 1'b0;
      State         = 3'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule
